// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RISC control sequencer: opcodes, ALU ops, states,
// IR field positions and the control-strobe bundle.
package cpu_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                           OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                           OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHL  = 5'd8,
                           OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11,
                           OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14,
                           OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17,
                           OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20,
                           OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23,
                           OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd3;
    localparam logic [4:0] ALU_INC  = 5'd31;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic [4:0] alu_op;
        logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out;
        logic c_out, inport_out, r_out, ba_out;
        logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
        logic r_in, con_in, outport_in;
        logic gra, grb, grc;
        logic read, write;
    } ctrl_t;

    // Final execute step of each instruction; unlisted opcodes are one-step no-ops.
    function automatic state_t last_step(logic [4:0] opc);
        case (opc)
            OP_JAL, OP_NEG, OP_NOT:                          last_step = S_T4;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_step = S_T5;
            OP_MUL, OP_DIV, OP_BR:                           last_step = S_T6;
            OP_LD, OP_ST:                                    last_step = S_T7;
            default:                                         last_step = S_T3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps the current control step, opcode, branch
// flag and halt request onto the datapath control bundle.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con,
    input  logic       stop,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_T0: if (!stop) begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALU_INC;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            S_T3: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                end
                OP_NEG, OP_NOT: begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode;
                end
                OP_MUL, OP_DIV: begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                end
                // Base register is gated through BAout so r0 reads as zero for addressing.
                OP_LD, OP_LDI, OP_ST: begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                end
                OP_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                OP_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                OP_JAL:  begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
                OP_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                OP_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                default: ;
            endcase
            S_T4: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                    ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode;
                end
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode;
                end
                OP_NEG, OP_NOT: begin
                    ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end
                OP_MUL, OP_DIV: begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode;
                end
                OP_LD, OP_LDI, OP_ST: begin
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALU_ADD;
                end
                OP_BR:  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                OP_JAL: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                default: ;
            endcase
            S_T5: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                    ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end
                OP_MUL, OP_DIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                OP_LD, OP_ST:   begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
                OP_BR: begin
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = ALU_ADD;
                end
                default: ;
            endcase
            S_T6: case (opcode)
                OP_MUL, OP_DIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                OP_LD:          begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                OP_ST: begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                end
                OP_BR: if (con) begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; end
                default: ;
            endcase
            S_T7: case (opcode)
                OP_LD: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                OP_ST: ctrl.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer for the 32-bit RISC datapath: holds the step
// register and sequencing rules; strobes come from ctrl_decode.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  OpCode,
    output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    output logic        Cout, InPortout, Rout, BAout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output logic        Rin, CONin, OutportIn,
    output logic        Gra, Grb, Grc,
    output logic        Read, Write
);

    state_t     state;
    ctrl_t      ctrl;
    logic [4:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = IR[OPC_MSB:OPC_LSB];
    assign unused_ir_bits = ^IR[OPC_LSB-1:0];

    // Execute steps advance until the opcode's final step; a changed opcode
    // that is already past its final step also returns to fetch.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= Stop ? S_HALT : S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_HALT:  state <= S_HALT;
                default: begin
                    if (state == S_T3 && opcode == OP_HALT)
                        state <= S_HALT;
                    else if (state >= last_step(opcode))
                        state <= S_T0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .con    (CON),
        .stop   (Stop),
        .ctrl   (ctrl)
    );

    assign Run       = (state != S_HALT);
    assign OpCode    = ctrl.alu_op;
    assign PCout     = ctrl.pc_out;
    assign MDRout    = ctrl.mdr_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign Zlowout   = ctrl.zlow_out;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign Cout      = ctrl.c_out;
    assign InPortout = ctrl.inport_out;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign PCin      = ctrl.pc_in;
    assign IRin      = ctrl.ir_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign Rin       = ctrl.r_in;
    assign CONin     = ctrl.con_in;
    assign OutportIn = ctrl.outport_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level model expands each
// opcode into its per-cycle strobe words and a compare process checks every cycle.
module tb_control_unit;

    localparam int PCOUT = 0, MDROUT = 1, ZHIGHOUT = 2, ZLOWOUT = 3, HIOUT = 4, LOOUT = 5,
                   COUT = 6, INPORTOUT = 7, ROUT = 8, BAOUT = 9, PCIN = 10, IRIN = 11,
                   MARIN = 12, MDRIN = 13, YIN = 14, ZIN = 15, HIIN = 16, LOIN = 17,
                   RIN = 18, CONIN = 19, OUTPORTIN = 20, GRA = 21, GRB = 22, GRC = 23,
                   READ = 24, WRITE = 25;

    typedef struct packed {
        logic        run;
        logic [4:0]  op;
        logic [25:0] st;
    } exp_t;

    typedef struct {
        exp_t e;
        int   op;
        int   step;
    } item_t;

    localparam exp_t RST_W  = '{run: 1'b1, op: 5'd0, st: 26'd0};
    localparam exp_t HALT_W = '{run: 1'b0, op: 5'd0, st: 26'd0};

    logic        clk = 1'b0;
    logic        clr, CON, Stop;
    logic [31:0] IR;
    logic        Run;
    logic [4:0]  OpCode;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout, Rout, BAout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn;
    logic        Gra, Grb, Grc, Read, Write;
    logic [31:0] act;

    item_t exp_q[$];
    exp_t  seq[$];
    int    total = 0;
    int    bad = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run), .OpCode(OpCode),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .Rout(Rout),
        .BAout(BAout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write)
    );

    assign act = {Run, OpCode, Write, Read, Grc, Grb, Gra, OutportIn, CONin, Rin, LOin, HIin,
                  Zin, Yin, MDRin, MARin, IRin, PCin, BAout, Rout, InPortout, Cout, LOout,
                  HIout, Zlowout, Zhighout, MDRout, PCout};

    always #5 clk = ~clk;

    function automatic logic [25:0] f(int i);
        logic [25:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic exp_t w(int op, logic [25:0] m);
        exp_t e;
        e.run = 1'b1;
        e.op  = 5'(op);
        e.st  = m;
        return e;
    endfunction

    // Whole-instruction expansion: fetch, then the opcode's listed steps, then
    // halt_n HALT cycles if the instruction halts.
    function automatic void build(int opc, bit con, bit stop, int halt_n);
        seq.delete();
        if (stop) begin
            seq.push_back(w(0, '0));
            repeat (halt_n) seq.push_back(HALT_W);
            return;
        end
        seq.push_back(w(31, f(PCOUT) | f(MARIN) | f(ZIN)));
        seq.push_back(w(0, f(ZLOWOUT) | f(PCIN) | f(READ) | f(MDRIN)));
        seq.push_back(w(0, f(MDROUT) | f(IRIN)));
        if (opc >= 3 && opc <= 13) begin
            seq.push_back(w(0, f(GRB) | f(ROUT) | f(YIN)));
            if (opc <= 10) seq.push_back(w(opc, f(GRC) | f(ROUT) | f(ZIN)));
            else           seq.push_back(w(opc, f(COUT) | f(ZIN)));
            seq.push_back(w(0, f(ZLOWOUT) | f(GRA) | f(RIN)));
        end else if (opc == 16 || opc == 17) begin
            seq.push_back(w(opc, f(GRB) | f(ROUT) | f(ZIN)));
            seq.push_back(w(0, f(ZLOWOUT) | f(GRA) | f(RIN)));
        end else if (opc == 14 || opc == 15) begin
            seq.push_back(w(0, f(GRA) | f(ROUT) | f(YIN)));
            seq.push_back(w(opc, f(GRB) | f(ROUT) | f(ZIN)));
            seq.push_back(w(0, f(ZLOWOUT) | f(LOIN)));
            seq.push_back(w(0, f(ZHIGHOUT) | f(HIIN)));
        end else if (opc <= 2) begin
            seq.push_back(w(0, f(GRB) | f(ROUT) | f(BAOUT) | f(YIN)));
            seq.push_back(w(3, f(COUT) | f(ZIN)));
            if (opc == 1) begin
                seq.push_back(w(0, f(ZLOWOUT) | f(GRA) | f(RIN)));
            end else begin
                seq.push_back(w(0, f(ZLOWOUT) | f(MARIN)));
                if (opc == 0) begin
                    seq.push_back(w(0, f(READ) | f(MDRIN)));
                    seq.push_back(w(0, f(MDROUT) | f(GRA) | f(RIN)));
                end else begin
                    seq.push_back(w(0, f(GRA) | f(ROUT) | f(MDRIN)));
                    seq.push_back(w(0, f(WRITE)));
                end
            end
        end else begin
            case (opc)
                18: begin
                    seq.push_back(w(0, f(GRA) | f(ROUT) | f(CONIN)));
                    seq.push_back(w(0, f(PCOUT) | f(YIN)));
                    seq.push_back(w(3, f(COUT) | f(ZIN)));
                    seq.push_back(w(0, con ? (f(ZLOWOUT) | f(PCIN)) : 26'd0));
                end
                19: seq.push_back(w(0, f(GRA) | f(ROUT) | f(PCIN)));
                20: begin
                    seq.push_back(w(0, f(PCOUT) | f(GRB) | f(RIN)));
                    seq.push_back(w(0, f(GRA) | f(ROUT) | f(PCIN)));
                end
                21: seq.push_back(w(0, f(INPORTOUT) | f(GRA) | f(RIN)));
                22: seq.push_back(w(0, f(GRA) | f(ROUT) | f(OUTPORTIN)));
                23: seq.push_back(w(0, f(HIOUT) | f(GRA) | f(RIN)));
                24: seq.push_back(w(0, f(LOOUT) | f(GRA) | f(RIN)));
                26: begin
                    seq.push_back(w(0, '0));
                    repeat (halt_n) seq.push_back(HALT_W);
                end
                default: seq.push_back(w(0, '0));
            endcase
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic push_exp(input exp_t e, input int op, input int step);
        item_t it;
        it.e = e;
        it.op = op;
        it.step = step;
        exp_q.push_back(it);
    endtask

    // Drives one instruction, holding IR for its whole duration; limit cuts it short.
    task automatic run_instr(input int opc, input bit con, input bit stop, input int halt_n,
                             input int limit, input logic [31:0] ir);
        build(opc, con, stop, halt_n);
        for (int i = 0; i < seq.size() && i < limit; i++) begin
            @(posedge clk); #1;
            IR   = ir;
            Stop = (i == 0) ? stop : ($urandom_range(0, 3) == 0);
            CON  = (opc == 18 && i == 6) ? con : 1'($urandom_range(0, 1));
            push_exp(seq[i], opc, i);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clr = 1'b0;
        Stop = 1'b0;
        push_exp(RST_W, -1, 0);
        @(posedge clk); #1;
        clr = 1'b1;
        push_exp(RST_W, -1, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item_t it;
            it = exp_q.pop_front();
            total++;
            if (act !== it.e) begin
                bad++;
                $display("FAIL cycle op=%0d step=%0d got=%h want=%h", it.op, it.step, act, it.e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    int pin_op[13]  = '{25, 19, 21, 20, 16, 3, 11, 14, 18, 0, 2, 29, 1};
    int pin_len[13] = '{ 4,  4,  4,  5,  5, 6,  6,  7,  7, 8, 8,  4, 6};

    initial begin
        int opc;
        bit stp;
        clr = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0;
        #2 clr = 1'b0;
        #1 chk("reset_state", act, RST_W);
        @(posedge clk); #1;
        clr = 1'b1;
        push_exp(RST_W, -1, 0);

        foreach (pin_op[k]) begin
            build(pin_op[k], 1'b1, 1'b0, 0);
            chk($sformatf("model_len_op%0d", pin_op[k]), 32'(seq.size()), 32'(pin_len[k]));
        end
        build(3, 1'b0, 1'b0, 0);
        chk("model_add_t0", seq[0], 32'hFC00_9001);
        chk("model_add_t4", seq[4], 32'h8C80_8100);

        run_instr(3, 1'b0, 1'b0, 0, 99, {5'd3, 4'd1, 4'd2, 4'd3, 15'd0});
        run_instr(0, 1'b0, 1'b0, 0, 99, {5'd0, 27'h123_4567});
        run_instr(2, 1'b0, 1'b0, 0, 99, {5'd2, 27'h765_4321});
        run_instr(18, 1'b1, 1'b0, 0, 99, {5'd18, 27'h0});
        run_instr(18, 1'b0, 1'b0, 0, 99, {5'd18, 27'h0});
        run_instr(20, 1'b0, 1'b0, 0, 99, {5'd20, 27'h0});

        // Abandon a load in T5 with an asynchronous clear.
        run_instr(0, 1'b0, 1'b0, 0, 5, {5'd0, 27'h0});
        @(posedge clk); #1;
        chk("ld_t5", act, 32'h8000_1008);
        clr = 1'b0;
        #1 chk("clr_async", act, RST_W);
        @(posedge clk); #1;
        chk("clr_hold", act, RST_W);
        clr = 1'b1;
        push_exp(RST_W, -1, 0);
        run_instr(25, 1'b0, 1'b0, 0, 99, {5'd25, 27'h0});

        run_instr(26, 1'b0, 1'b0, 20, 99, {5'd26, 27'h0});
        do_reset();
        run_instr(5, 1'b0, 1'b1, 20, 99, {5'd5, 27'h0});
        do_reset();

        for (int n = 0; n < 300; n++) begin
            opc = $urandom_range(0, 31);
            stp = ($urandom_range(0, 24) == 0);
            run_instr(opc, 1'($urandom_range(0, 1)), stp, $urandom_range(1, 4), 99,
                      {5'(opc), 27'($urandom)});
            if (stp || opc == 26) do_reset();
        end

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
